hz_pipe_track: RTL and testbench
================================

Name: hz_pipe_track

Overview:
- Pipeline-side counterpart of the hazard controller: it produces the stage-tagged register-address and control fields that the hazard controller consumes, and it carries out that controller's stall/clear decisions.
- Holds the EX, MEM and WB tracking registers for the 5-stage MIPS pipeline.
- Injects bubbles on load-use stall, applies pipeline flushes and freezes on memory wait.
- Sits beside the datapath ID/EX, EX/MEM and MEM/WB registers, clocked identically.

Parameters:
- AW, 5, register-address width
- PCW, 32, PC width carried for debug/retire
- CNT_W, 32, performance counter width (only used with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  AW  ID source register A
- id_rt  in  AW  ID source register B
- id_wa  in  AW  ID destination register (already muxed rt/rd/31)
- id_memtoreg  in  1  ID instruction is a load
- id_regwrite  in  1  ID instruction writes the register file
- id_pc  in  PCW  ID instruction PC
- stall_in  in  1  load-use stall/clear from the hazard controller
- hold  in  1  global freeze (memory wait)
- flush_all  in  1  pulse: kill EX and MEM contents (exception/redirect)
- EX_Rs, EX_Rt, EX_WA  out  AW  EX-stage fields
- MEM_WA, WB_WA  out  AW  MEM and WB destination registers
- EX_MemtoReg, MEM_MemtoReg  out  1  load flags, gated by stage valid
- EX_RegWrite, MEM_RegWrite, WB_RegWrite  out  1  write enables, gated by stage valid
- wb_valid  out  1  WB holds a real instruction
- wb_pc  out  PCW  PC of the WB instruction
- flush_pending  out  1  a flush was received during hold and is not yet applied

Behaviour:
- Reset (async, rst_n=0): all stage valids 0, every field and output 0, flush_pending 0, counters 0. Reset mid-operation discards all in-flight state immediately.
- Each stage register set = {valid, rs, rt, wa, memtoreg, regwrite, pc}. MEM and WB keep only the fields they need.
- Every output is registered (no combinational path from inputs). Latency ID->EX is 1 cycle; EX->MEM and MEM->WB are 1 cycle each.
- Control outputs are ANDed with the stage valid. A bubble stage has all fields zeroed, so WA=0 and the hazard controller sees no match.
- Priority per cycle: reset > hold > flush (flush_all or flush_pending) > stall_in > normal advance.
- hold=1:
  - All stage registers keep their values.
  - A flush_all seen during hold sets flush_pending.
  - stall_in is ignored.
- Flush, when not held:
  - EX loads a bubble; MEM loads a bubble; WB takes the old MEM contents normally, so older instructions retire.
  - flush_pending clears that cycle.
  - ID contents are discarded, because EX loads a bubble rather than ID.
- stall_in=1, no hold/flush: EX loads a bubble (ID is held upstream); MEM<=EX; WB<=MEM.
- Normal advance: EX<=ID (valid = id_valid); MEM<=EX; WB<=MEM.
- Back-to-back stalls insert consecutive bubbles; no limit.
- flush_all asserted while flush_pending is already 1: single flush, no double effect.
- No combinational dependency on the hazard controller outputs other than stall_in.

Optional Feature:
- Macro HZ_PERF_CNT_EN.
- Defined:
  - Adds outputs cycle_cnt, retire_cnt, stall_cnt (CNT_W each, reset 0, wrap at 2^CNT_W-1 -> 0).
  - cycle_cnt increments every cycle out of reset.
  - retire_cnt increments when WB is loaded with valid=1 and hold=0.
  - stall_cnt increments on each cycle where stall_in=1 and hold=0 and no flush applies.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Straight-line: feed 3 valid instrs (wa=8,9,10, regwrite=1) on consecutive cycles -> EX_WA=8 at cycle 1, MEM_WA=8 at cycle 2, WB_WA=8 and WB_RegWrite=1 at cycle 3; wb_pc tracks id_pc.
- Load-use: lw wa=4 (memtoreg=1), then stall_in=1 for one cycle -> EX_WA=0, EX_RegWrite=0, EX_MemtoReg=0 that cycle; MEM_WA=4, MEM_MemtoReg=1; the dependent instruction enters EX the next cycle.
- Hold with flush: hold=1 for 3 cycles, flush_all pulsed in the second cycle -> all outputs frozen, flush_pending=1; on the first cycle with hold=0, EX and MEM become bubbles, WB takes the old MEM contents, flush_pending=0.
- Flush vs stall: flush_all=1 and stall_in=1 in the same cycle -> flush result, stall_cnt unchanged (with HZ_PERF_CNT_EN).
- Async reset mid-stream: pull rst_n low between clock edges with all stages valid -> all outputs 0 immediately, without waiting for a clock edge.
- Counter wrap (CNT_W=4, HZ_PERF_CNT_EN): run 16 cycles -> cycle_cnt returns to 0; retire_cnt equals the number of valid WB loads.

Source files
------------

// File: rtl/hz_pipe_track.sv
// hz_pipe_track
// Stage-tracking registers for a 5-stage MIPS pipeline. They sit beside the
// datapath ID/EX, EX/MEM and MEM/WB registers and carry the register-address
// and control fields that the hazard controller compares against. This block
// also carries out that controller's decisions: it inserts bubbles on a
// load-use stall, kills EX and MEM on a flush, and freezes every stage on a
// memory wait.
//
// Per-cycle priority: reset > hold > flush (flush_all or flush_pending)
//                     > stall_in > normal advance.
//
// Optional feature: define HZ_PERF_CNT_EN to add the cycle_cnt, retire_cnt
// and stall_cnt performance counters. Without it those ports and registers
// are absent.
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   id_*                        ID-stage instruction fields (valid, rs, rt, wa,
//                               memtoreg, regwrite, pc)
//   stall_in                    load-use stall: EX takes a bubble
//   hold                        global freeze; a flush seen while frozen is deferred
//   flush_all                   pulse that kills EX and MEM
//   EX_Rs, EX_Rt, EX_WA         EX-stage register addresses
//   MEM_WA, WB_WA               MEM and WB destination registers
//   EX_/MEM_MemtoReg            load flags, gated by stage valid
//   EX_/MEM_/WB_RegWrite        write enables, gated by stage valid
//   wb_valid, wb_pc             WB occupancy and the PC of the WB instruction
//   flush_pending               a flush arrived during hold and has not been applied
//   cycle_cnt, retire_cnt,      performance counters (HZ_PERF_CNT_EN only)
//   stall_cnt
module hz_pipe_track #(
    parameter int AW    = 5,
    parameter int PCW   = 32,
    parameter int CNT_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           id_valid,
    input  logic [AW-1:0]  id_rs,
    input  logic [AW-1:0]  id_rt,
    input  logic [AW-1:0]  id_wa,
    input  logic           id_memtoreg,
    input  logic           id_regwrite,
    input  logic [PCW-1:0] id_pc,
    input  logic           stall_in,
    input  logic           hold,
    input  logic           flush_all,
    output logic [AW-1:0]  EX_Rs,
    output logic [AW-1:0]  EX_Rt,
    output logic [AW-1:0]  EX_WA,
    output logic [AW-1:0]  MEM_WA,
    output logic [AW-1:0]  WB_WA,
    output logic           EX_MemtoReg,
    output logic           MEM_MemtoReg,
    output logic           EX_RegWrite,
    output logic           MEM_RegWrite,
    output logic           WB_RegWrite,
    output logic           wb_valid,
    output logic [PCW-1:0] wb_pc,
    output logic           flush_pending
`ifdef HZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    typedef struct packed {
        logic           valid;
        logic [AW-1:0]  rs;
        logic [AW-1:0]  rt;
        logic [AW-1:0]  wa;
        logic           memtoreg;
        logic           regwrite;
        logic [PCW-1:0] pc;
    } ex_t;

    typedef struct packed {
        logic           valid;
        logic [AW-1:0]  wa;
        logic           memtoreg;
        logic           regwrite;
        logic [PCW-1:0] pc;
    } mem_t;

    typedef struct packed {
        logic           valid;
        logic [AW-1:0]  wa;
        logic           regwrite;
        logic [PCW-1:0] pc;
    } wb_t;

    ex_t  ex_q;
    mem_t mem_q;
    wb_t  wb_q;
    ex_t  id_cand;
    logic flush_go;

    // A deferred flush is applied on the first unfrozen cycle, in the same way
    // as a live pulse. A pulse that arrives while a flush is already pending
    // merges with it, so the flush takes effect only once.
    assign flush_go = flush_all | flush_pending;

    // An invalid ID slot enters EX with every field zeroed. The hazard
    // controller then sees WA=0 and finds no match.
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        id_cand = '0;
        if (id_valid) begin
            id_cand = '{valid: 1'b1, rs: id_rs, rt: id_rt, wa: id_wa,
                        memtoreg: id_memtoreg, regwrite: id_regwrite, pc: id_pc};
        end
    end

    // NOTE: state registers use non-blocking assignments, so every stage samples the pre-edge value of its predecessor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            flush_pending <= 1'b0;
        end else if (hold) begin
            if (flush_all) flush_pending <= 1'b1;
        end else begin
            // WB always drains MEM when not frozen. A flush therefore still
            // lets the older instruction retire.
            wb_q          <= '{valid: mem_q.valid, wa: mem_q.wa,
                               regwrite: mem_q.regwrite, pc: mem_q.pc};
            flush_pending <= 1'b0;
            if (flush_go) begin
                ex_q  <= '0;
                mem_q <= '0;
            end else begin
                mem_q <= '{valid: ex_q.valid, wa: ex_q.wa, memtoreg: ex_q.memtoreg,
                           regwrite: ex_q.regwrite, pc: ex_q.pc};
                ex_q  <= stall_in ? ex_t'('0) : id_cand;
            end
        end
    end

    assign EX_Rs        = ex_q.rs;
    assign EX_Rt        = ex_q.rt;
    assign EX_WA        = ex_q.wa;
    assign MEM_WA       = mem_q.wa;
    assign WB_WA        = wb_q.wa;
    assign EX_MemtoReg  = ex_q.valid  & ex_q.memtoreg;
    assign MEM_MemtoReg = mem_q.valid & mem_q.memtoreg;
    assign EX_RegWrite  = ex_q.valid  & ex_q.regwrite;
    assign MEM_RegWrite = mem_q.valid & mem_q.regwrite;
    assign WB_RegWrite  = wb_q.valid  & wb_q.regwrite;
    assign wb_valid     = wb_q.valid;
    assign wb_pc        = wb_q.pc;

`ifdef HZ_PERF_CNT_EN
    // The counters wrap naturally at 2^CNT_W. A retire is counted when WB
    // loads a valid instruction from MEM. A stall is counted only when
    // stall_in actually takes effect, so it is not counted under hold or
    // under a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (!hold && mem_q.valid)          retire_cnt <= retire_cnt + 1'b1;
            if (!hold && !flush_go && stall_in) stall_cnt  <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hz_pipe_track.sv
// Directed testbench for hz_pipe_track. Every expected value below is worked
// out by hand from the pipeline rules. The counter checks are compiled only
// when HZ_PERF_CNT_EN is defined.
module tb_hz_pipe_track;

    localparam int AW    = 5;
    localparam int PCW   = 32;
    localparam int CNT_W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           id_valid = 1'b0;
    logic [AW-1:0]  id_rs = '0, id_rt = '0, id_wa = '0;
    logic           id_memtoreg = 1'b0, id_regwrite = 1'b0;
    logic [PCW-1:0] id_pc = '0;
    logic           stall_in = 1'b0, hold = 1'b0, flush_all = 1'b0;

    logic [AW-1:0]  EX_Rs, EX_Rt, EX_WA, MEM_WA, WB_WA;
    logic           EX_MemtoReg, MEM_MemtoReg;
    logic           EX_RegWrite, MEM_RegWrite, WB_RegWrite;
    logic           wb_valid, flush_pending;
    logic [PCW-1:0] wb_pc;
`ifdef HZ_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt, retire_cnt, stall_cnt;
    logic [CNT_W-1:0] s0;
`endif

    hz_pipe_track #(.AW(AW), .PCW(PCW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_wa(id_wa),
        .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite), .id_pc(id_pc),
        .stall_in(stall_in), .hold(hold), .flush_all(flush_all),
        .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_WA(EX_WA),
        .MEM_WA(MEM_WA), .WB_WA(WB_WA),
        .EX_MemtoReg(EX_MemtoReg), .MEM_MemtoReg(MEM_MemtoReg),
        .EX_RegWrite(EX_RegWrite), .MEM_RegWrite(MEM_RegWrite), .WB_RegWrite(WB_RegWrite),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .flush_pending(flush_pending)
`ifdef HZ_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic [AW-1:0] wa, input logic mtr, input logic rw,
                         input logic [PCW-1:0] pc);
        id_valid = v; id_rs = rs; id_rt = rt; id_wa = wa;
        id_memtoreg = mtr; id_regwrite = rw; id_pc = pc;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_ex_wa", 32'(EX_WA), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_flush_pending", 32'(flush_pending), 32'd0);
        #9 rst_n = 1'b1;   // released between edges

        // Straight-line: wa 8, 9, 10
        drive(1'b1, 5'd1, 5'd2, 5'd8, 1'b0, 1'b1, 32'h100);
        tick();
        check("sl_ex_wa_c1", 32'(EX_WA), 32'd8);
        check("sl_ex_rs_c1", 32'(EX_Rs), 32'd1);
        check("sl_ex_rw_c1", 32'(EX_RegWrite), 32'd1);
        drive(1'b1, 5'd3, 5'd4, 5'd9, 1'b0, 1'b1, 32'h104);
        tick();
        check("sl_mem_wa_c2", 32'(MEM_WA), 32'd8);
        check("sl_ex_wa_c2", 32'(EX_WA), 32'd9);
        drive(1'b1, 5'd5, 5'd6, 5'd10, 1'b0, 1'b1, 32'h108);
        tick();
        check("sl_wb_wa_c3", 32'(WB_WA), 32'd8);
        check("sl_wb_rw_c3", 32'(WB_RegWrite), 32'd1);
        check("sl_wb_pc_c3", wb_pc, 32'h100);
        check("sl_mem_wa_c3", 32'(MEM_WA), 32'd9);
        idle();
        tick();
        check("sl_wb_pc_c4", wb_pc, 32'h104);
        check("sl_ex_bubble_c4", 32'(EX_WA), 32'd0);
        drain();

        // Load-use
        drive(1'b1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 32'h200);
        tick();
        check("lu_ex_mtr", 32'(EX_MemtoReg), 32'd1);
`ifdef HZ_PERF_CNT_EN
        s0 = stall_cnt;
`endif
        drive(1'b1, 5'd4, 5'd2, 5'd5, 1'b0, 1'b1, 32'h204);
        stall_in = 1'b1;
        tick();
        check("lu_ex_wa", 32'(EX_WA), 32'd0);
        check("lu_ex_rw", 32'(EX_RegWrite), 32'd0);
        check("lu_ex_mtr_b", 32'(EX_MemtoReg), 32'd0);
        check("lu_mem_wa", 32'(MEM_WA), 32'd4);
        check("lu_mem_mtr", 32'(MEM_MemtoReg), 32'd1);
`ifdef HZ_PERF_CNT_EN
        check("lu_stall_cnt", 32'(stall_cnt), 32'(CNT_W'(s0 + 1'b1)));
`endif
        stall_in = 1'b0;
        tick();
        check("lu_dep_ex_wa", 32'(EX_WA), 32'd5);
        check("lu_dep_ex_rs", 32'(EX_Rs), 32'd4);
        check("lu_mem_bubble", 32'(MEM_WA), 32'd0);
        check("lu_wb_wa", 32'(WB_WA), 32'd4);
        drain();

        // Hold with flush: fill EX=13, MEM=12, WB=11
        drive(1'b1, 5'd0, 5'd0, 5'd11, 1'b0, 1'b1, 32'h300); tick();
        drive(1'b1, 5'd0, 5'd0, 5'd12, 1'b0, 1'b1, 32'h304); tick();
        drive(1'b1, 5'd0, 5'd0, 5'd13, 1'b0, 1'b1, 32'h308); tick();
        drive(1'b1, 5'd0, 5'd0, 5'd14, 1'b0, 1'b1, 32'h30c);
        hold = 1'b1; stall_in = 1'b1;          // stall ignored during hold
        tick();
        stall_in = 1'b0;
        check("hd1_ex_wa", 32'(EX_WA), 32'd13);
        check("hd1_mem_wa", 32'(MEM_WA), 32'd12);
        check("hd1_wb_wa", 32'(WB_WA), 32'd11);
        check("hd1_pending", 32'(flush_pending), 32'd0);
        flush_all = 1'b1;
        tick();
        flush_all = 1'b0;
        check("hd2_ex_wa", 32'(EX_WA), 32'd13);
        check("hd2_pending", 32'(flush_pending), 32'd1);
        flush_all = 1'b1;                       // repeat pulse while pending
        tick();
        flush_all = 1'b0;
        check("hd3_mem_wa", 32'(MEM_WA), 32'd12);
        check("hd3_wb_pc", wb_pc, 32'h300);
        check("hd3_pending", 32'(flush_pending), 32'd1);
        hold = 1'b0;
        tick();
        check("hf_ex_wa", 32'(EX_WA), 32'd0);
        check("hf_ex_rw", 32'(EX_RegWrite), 32'd0);
        check("hf_mem_wa", 32'(MEM_WA), 32'd0);
        check("hf_wb_wa", 32'(WB_WA), 32'd12);
        check("hf_wb_pc", wb_pc, 32'h304);
        check("hf_pending", 32'(flush_pending), 32'd0);
        tick();                                 // flush applied only once
        check("hf2_ex_wa", 32'(EX_WA), 32'd14);
        check("hf2_wb_valid", 32'(wb_valid), 32'd0);
        drain();

        // Flush and stall in the same cycle: the flush wins
        drive(1'b1, 5'd0, 5'd0, 5'd20, 1'b0, 1'b1, 32'h400); tick();
        drive(1'b1, 5'd0, 5'd0, 5'd21, 1'b0, 1'b1, 32'h404); tick();
        drive(1'b1, 5'd0, 5'd0, 5'd22, 1'b0, 1'b1, 32'h408);
`ifdef HZ_PERF_CNT_EN
        s0 = stall_cnt;
`endif
        flush_all = 1'b1; stall_in = 1'b1;
        tick();
        flush_all = 1'b0; stall_in = 1'b0;
        check("fs_ex_wa", 32'(EX_WA), 32'd0);
        check("fs_mem_wa", 32'(MEM_WA), 32'd0);
        check("fs_wb_wa", 32'(WB_WA), 32'd20);
`ifdef HZ_PERF_CNT_EN
        check("fs_stall_cnt", 32'(stall_cnt), 32'(s0));
`endif

        // Async reset mid-stream with all stages valid
        drive(1'b1, 5'd0, 5'd0, 5'd23, 1'b0, 1'b1, 32'h500); tick();
        drive(1'b1, 5'd0, 5'd0, 5'd24, 1'b0, 1'b1, 32'h504); tick();
        drive(1'b1, 5'd0, 5'd0, 5'd25, 1'b0, 1'b1, 32'h508); tick();
        check("ar_pre_wb_valid", 32'(wb_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("ar_ex_wa", 32'(EX_WA), 32'd0);
        check("ar_mem_wa", 32'(MEM_WA), 32'd0);
        check("ar_wb_wa", 32'(WB_WA), 32'd0);
        check("ar_wb_valid", 32'(wb_valid), 32'd0);
        check("ar_wb_pc", wb_pc, 32'd0);
        check("ar_ex_rw", 32'(EX_RegWrite), 32'd0);
        drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b1, 32'h600);
        #2 rst_n = 1'b1;

`ifdef HZ_PERF_CNT_EN
        // Counter wrap: 16 cycles from reset, valid instructions every cycle.
        // WB loads a valid entry on edges 3..16, which gives 14 retires.
        check("cw_cycle0", 32'(cycle_cnt), 32'd0);
        repeat (16) tick();
        check("cw_cycle_wrap", 32'(cycle_cnt), 32'd0);
        check("cw_retire", 32'(retire_cnt), 32'd14);
        check("cw_stall", 32'(stall_cnt), 32'd0);
`else
        tick();
        check("post_rst_ex_wa", 32'(EX_WA), 32'd7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
